// File: rtl/wb_hyperram_pkg.sv
// Shared types and constants for the Wishbone HyperRAM arbiter.
package wb_hyperram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Stall watchdog: counts cycles while enabled and pulses tc_o on the cycle
// that would carry the count to TERMINAL, unless that cycle also clears it.
module wb_timeout_cnt
  import wb_hyperram_pkg::*;
#(
  parameter int TERMINAL = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc_o = enable & ~clear & (cnt == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/wb_hyperram_arbiter.sv
// Two-master Wishbone arbiter in front of wb_hyperram: alternating grant on
// ties, no pre-emption inside a cycle, and a watchdog that aborts stalled cycles.
module wb_hyperram_arbiter
  import wb_hyperram_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rstn_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic            s_ack_i,
  input  logic [DW-1:0]   s_dat_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  arb_state_t state;
  logic       last_served;
  logic       abort;
  logic       tc;
  logic       gnt0, gnt1;
  logic            own_cyc, own_stb, own_we;
  logic [DW/8-1:0] own_sel;
  logic [AW-1:0]   own_adr;
  logic [DW-1:0]   own_dat;

  assign gnt0 = (state == GNT0);
  assign gnt1 = (state == GNT1);

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_sel = '0;
    own_adr = '0;
    own_dat = '0;
    case (state)
      GNT0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        own_we  = m0_we_i;
        own_sel = m0_sel_i;
        own_adr = m0_adr_i;
        own_dat = m0_dat_i;
      end
      GNT1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
        own_we  = m1_we_i;
        own_sel = m1_sel_i;
        own_adr = m1_adr_i;
        own_dat = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign s_cyc_o  = own_cyc & ~abort;
  assign s_stb_o  = own_stb & ~abort;
  assign s_we_o   = own_we;
  assign s_sel_o  = own_sel;
  assign s_adr_o  = own_adr;
  assign s_dat_o  = own_dat;

  assign m0_ack_o = s_ack_i & gnt0 & ~abort;
  assign m1_ack_o = s_ack_i & gnt1 & ~abort;
  assign m0_err_o = tc & gnt0;
  assign m1_err_o = tc & gnt1;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o  = {gnt1, gnt0};

  // Being in IDLE also covers the clear on grant entry.
  wb_timeout_cnt #(.TERMINAL(TIMEOUT)) u_timeout_cnt (
    .clk    (wb_clk_i),
    .rst_n  (wb_rstn_i),
    .clear  ((state == IDLE) | s_ack_i | ~s_stb_o),
    .enable (s_stb_o),
    .tc_o   (tc)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state       <= IDLE;
      last_served <= 1'b1;
      abort       <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            state <= last_served ? GNT0 : GNT1;
          end else if (m0_cyc_i) begin
            state <= GNT0;
          end else if (m1_cyc_i) begin
            state <= GNT1;
          end
        end
        GNT0: begin
          if (!m0_cyc_i) begin
            state       <= IDLE;
            last_served <= 1'b0;
            abort       <= 1'b0;
          end else if (tc) begin
            abort     <= 1'b1;
            timeout_o <= 1'b1;
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            state       <= IDLE;
            last_served <= 1'b1;
            abort       <= 1'b0;
          end else if (tc) begin
            abort     <= 1'b1;
            timeout_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_hyperram_arbiter.sv
// Self-checking bench for wb_hyperram_arbiter: a cycle-level ownership model
// checks every cycle, with a vector table and directed corner-case sequences.
module tb_wb_hyperram_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]    m0_sel, m1_sel, s_sel;
  logic [31:0]   m0_adr, m1_adr, m0_wdat, m1_wdat;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0]   m0_rdat, m1_rdat;
  logic          s_cyc, s_stb, s_we, s_ack;
  logic [31:0]   s_adr, s_wdat, s_rdat;
  logic [1:0]    grant;
  logic          timeout;

  always #5 clk = ~clk;

  wb_hyperram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i (clk),      .wb_rstn_i (rstn),
    .m0_cyc_i (m0_cyc),   .m0_stb_i (m0_stb),   .m0_we_i (m0_we),
    .m0_sel_i (m0_sel),   .m0_adr_i (m0_adr),   .m0_dat_i (m0_wdat),
    .m0_ack_o (m0_ack),   .m0_err_o (m0_err),   .m0_dat_o (m0_rdat),
    .m1_cyc_i (m1_cyc),   .m1_stb_i (m1_stb),   .m1_we_i (m1_we),
    .m1_sel_i (m1_sel),   .m1_adr_i (m1_adr),   .m1_dat_i (m1_wdat),
    .m1_ack_o (m1_ack),   .m1_err_o (m1_err),   .m1_dat_o (m1_rdat),
    .s_cyc_o  (s_cyc),    .s_stb_o  (s_stb),    .s_we_o  (s_we),
    .s_sel_o  (s_sel),    .s_adr_o  (s_adr),    .s_dat_o (s_wdat),
    .s_ack_i  (s_ack),    .s_dat_i  (s_rdat),
    .grant_o  (grant),    .timeout_o (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner (-1 idle), last served master, stalled-cycle count.
  int own, last, stall;
  bit abort_m, sticky_m;
  bit exp_gc, exp_stb, exp_err;

  typedef struct {
    logic [4:0] stim;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[14];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check_output(name, 32'(act), 32'(exp));
  endtask

  task automatic model_reset();
    own = -1; last = 1; stall = 0; abort_m = 0; sticky_m = 0;
  endtask

  task automatic cycle_begin();
    logic gc, gs, gw;
    logic [3:0] gsel;
    logic [31:0] gadr, gdat;
    logic [1:0] egrant;
    @(negedge clk);
    gc = 0; gs = 0; gw = 0; gsel = '0; gadr = '0; gdat = '0; egrant = 2'b00;
    if (own == 0) begin
      gc = m0_cyc; gs = m0_stb; gw = m0_we; gsel = m0_sel; gadr = m0_adr; gdat = m0_wdat; egrant = 2'b01;
    end else if (own == 1) begin
      gc = m1_cyc; gs = m1_stb; gw = m1_we; gsel = m1_sel; gadr = m1_adr; gdat = m1_wdat; egrant = 2'b10;
    end
    exp_gc  = gc;
    exp_stb = gs & ~abort_m;
    exp_err = exp_stb & ~s_ack & (stall == TIMEOUT - 1);
    check_bit("s_cyc", s_cyc, gc & ~abort_m);
    check_bit("s_stb", s_stb, exp_stb);
    check_bit("s_we", s_we, gw);
    check_output("s_sel", 32'(s_sel), 32'(gsel));
    check_output("s_adr", s_adr, gadr);
    check_output("s_dat", s_wdat, gdat);
    check_bit("m0_ack", m0_ack, (own == 0) & s_ack & ~abort_m);
    check_bit("m1_ack", m1_ack, (own == 1) & s_ack & ~abort_m);
    check_bit("m0_err", m0_err, (own == 0) & exp_err);
    check_bit("m1_err", m1_err, (own == 1) & exp_err);
    check_output("m0_dat", m0_rdat, s_rdat);
    check_output("m1_dat", m1_rdat, s_rdat);
    check_output("grant", 32'(grant), 32'(egrant));
    check_bit("timeout", timeout, sticky_m);
  endtask

  task automatic cycle_end();
    @(posedge clk);
    if (own < 0) begin
      if (m0_cyc && m1_cyc) own = (last == 1) ? 0 : 1;
      else if (m0_cyc) own = 0;
      else if (m1_cyc) own = 1;
      stall = 0;
    end else if (!exp_gc) begin
      last = own; own = -1; abort_m = 0; stall = 0;
    end else begin
      if (exp_err) begin abort_m = 1; sticky_m = 1; end
      if (exp_stb && !s_ack) stall++;
      else stall = 0;
    end
    #1;
  endtask

  task automatic apply_stimulus(input int n);
    for (int k = 0; k < n; k++) begin
      cycle_begin();
      cycle_end();
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack} = '0;
    m0_sel = 4'hF; m1_sel = 4'h3;
    m0_adr = 32'h1000_0000; m1_adr = 32'h2000_0000;
    m0_wdat = 32'h0A0A_0A0A; m1_wdat = 32'h0B0B_0B0B; s_rdat = 32'h1234_5678;

    // stim = {c0,s0,c1,s1,ack}; exp = {grant[1:0], s_stb, m0_ack, m1_ack}
    vecs[0]  = '{5'b00000, 5'b00000};
    vecs[1]  = '{5'b11110, 5'b00000};
    vecs[2]  = '{5'b11111, 5'b01110};
    vecs[3]  = '{5'b00110, 5'b01000};
    vecs[4]  = '{5'b11110, 5'b00000};
    vecs[5]  = '{5'b11111, 5'b10101};
    vecs[6]  = '{5'b11000, 5'b10000};
    vecs[7]  = '{5'b11110, 5'b00000};
    vecs[8]  = '{5'b11111, 5'b01110};
    vecs[9]  = '{5'b00110, 5'b01000};
    vecs[10] = '{5'b11110, 5'b00000};
    vecs[11] = '{5'b11111, 5'b10101};
    vecs[12] = '{5'b00000, 5'b10000};
    vecs[13] = '{5'b00000, 5'b00000};

    do_reset();
    apply_stimulus(1);

    // Tie arbitration: alternating grants with an idle cycle between owners.
    for (int i = 0; i < 14; i++) begin
      {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack} = vecs[i].stim;
      cycle_begin();
      check_output($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp[4:3]));
      check_bit($sformatf("vec%0d_stb", i), s_stb, vecs[i].exp[2]);
      check_bit($sformatf("vec%0d_ack0", i), m0_ack, vecs[i].exp[1]);
      check_bit($sformatf("vec%0d_ack1", i), m1_ack, vecs[i].exp[0]);
      cycle_end();
    end

    // Single m0 read, slave acks in the fifth strobe cycle.
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h3000_0010;
    cycle_begin(); check_bit("rd_stb_before", s_stb, 1'b0); cycle_end();
    cycle_begin(); check_bit("rd_stb_after", s_stb, 1'b1);
    check_output("rd_adr", s_adr, 32'h3000_0010); cycle_end();
    apply_stimulus(3);
    s_ack = 1; s_rdat = 32'hDEAD_BEEF;
    cycle_begin();
    check_bit("rd_ack0", m0_ack, 1'b1);
    check_output("rd_dat0", m0_rdat, 32'hDEAD_BEEF);
    check_bit("rd_ack1", m1_ack, 1'b0);
    cycle_end();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    cycle_begin(); check_bit("rd_ack_once", m0_ack, 1'b0); cycle_end();
    apply_stimulus(1);

    // m1 holds its cycle over three back-to-back writes while m0 waits.
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m1_we = 1;
    apply_stimulus(1);
    for (int i = 0; i < 3; i++) begin
      s_ack = 1; m1_adr = 32'h2000_0100 + 32'(i * 4);
      cycle_begin();
      check_output($sformatf("bb%0d_grant", i), 32'(grant), 32'h2);
      check_bit($sformatf("bb%0d_ack1", i), m1_ack, 1'b1);
      check_bit($sformatf("bb%0d_ack0", i), m0_ack, 1'b0);
      cycle_end();
    end
    s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    cycle_begin(); check_output("bb_drop_grant", 32'(grant), 32'h2); cycle_end();
    cycle_begin(); check_output("bb_idle_grant", 32'(grant), 32'h0); cycle_end();
    cycle_begin(); check_output("bb_m0_grant", 32'(grant), 32'h1); cycle_end();
    s_ack = 1; apply_stimulus(1);
    s_ack = 0; m0_cyc = 0; m0_stb = 0; apply_stimulus(1);

    // Ack exactly on the eighth stalled cycle wins over the watchdog.
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    apply_stimulus(8);
    s_ack = 1;
    cycle_begin();
    check_bit("tc_ack_fwd", m0_ack, 1'b1);
    check_bit("tc_ack_noerr", m0_err, 1'b0);
    cycle_end();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    cycle_begin(); check_bit("tc_ack_nosticky", timeout, 1'b0); cycle_end();

    // Slave never acks: abort on the eighth stalled cycle.
    m0_cyc = 1; m0_stb = 1;
    apply_stimulus(8);
    cycle_begin();
    check_bit("to_err", m0_err, 1'b1);
    check_bit("to_cyc_still", s_cyc, 1'b1);
    cycle_end();
    s_ack = 1;
    cycle_begin();
    check_bit("to_err_once", m0_err, 1'b0);
    check_bit("to_cyc_drop", s_cyc, 1'b0);
    check_bit("to_sticky", timeout, 1'b1);
    check_output("to_grant_kept", 32'(grant), 32'h1);
    check_bit("to_late_ack", m0_ack, 1'b0);
    cycle_end();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    apply_stimulus(1);
    m1_cyc = 1; m1_stb = 1;
    apply_stimulus(2);
    s_ack = 1;
    cycle_begin(); check_bit("to_m1_ack", m1_ack, 1'b1); cycle_end();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    apply_stimulus(2);

    // Reset pulsed in the middle of an m0 read.
    m0_cyc = 1; m0_stb = 1;
    apply_stimulus(3);
    #3 s_ack = 1; rstn = 1'b0;
    #1;
    check_bit("rst_s_cyc", s_cyc, 1'b0);
    check_bit("rst_s_stb", s_stb, 1'b0);
    check_bit("rst_ack0", m0_ack, 1'b0);
    check_bit("rst_err0", m0_err, 1'b0);
    check_output("rst_grant", 32'(grant), 32'h0);
    check_bit("rst_timeout", timeout, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    m0_cyc = 0; m0_stb = 0; m1_cyc = 1; m1_stb = 1; rstn = 1'b1;
    cycle_begin(); check_bit("rst_late_ack0", m0_ack, 1'b0); cycle_end();
    s_ack = 0;
    cycle_begin(); check_output("rst_m1_grant", 32'(grant), 32'h2); cycle_end();
    s_ack = 1; apply_stimulus(1);
    s_ack = 0; m1_cyc = 0; m1_stb = 0; apply_stimulus(1);

    // Randomised traffic; the second half starves acks so timeouts occur.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(7) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(7) == 0) m1_cyc = ~m1_cyc;
      m0_stb  = m0_cyc & ($urandom_range(3) != 0);
      m1_stb  = m1_cyc & ($urandom_range(3) != 0);
      m0_we   = 1'($urandom_range(1));
      m1_we   = 1'($urandom_range(1));
      m0_sel  = 4'($urandom);
      m1_sel  = 4'($urandom);
      m0_adr  = $urandom; m1_adr = $urandom;
      m0_wdat = $urandom; m1_wdat = $urandom; s_rdat = $urandom;
      s_ack   = (c < 200) ? ($urandom_range(2) == 0) : ($urandom_range(11) == 0);
      apply_stimulus(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
